// File: rtl/cpld_uart_ctrl.sv
// CPLD UART handshake controller: borrows the shared BaseRAM data bus per byte,
// exposes data/status registers to the CPU and buffers one received byte.
module cpld_uart_ctrl #(
  parameter int RD_PULSE = 4,
  parameter int WR_PULSE = 4
) (
  input  logic        clk_50M,
  input  logic        reset_n,
  input  logic        req,
  input  logic        we,
  input  logic        addr,
  input  logic [7:0]  wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic [7:0]  bus_dout,
  output logic        bus_oe,
  input  logic [7:0]  bus_din,
  output logic        uart_rdn,
  output logic        uart_wrn,
  input  logic        uart_dataready,
  input  logic        uart_tbre,
  input  logic        uart_tsre
);

  typedef enum logic [3:0] {
    IDLE, RX_REQ, RX_LOW, RX_DONE,
    TX_REQ, TX_SETUP, TX_LOW, TX_HOLD, TX_TBRE, TX_TSRE
  } state_t;

  localparam logic [7:0] RD_LAST = 8'(RD_PULSE - 1);
  localparam logic [7:0] WR_LAST = 8'(WR_PULSE - 1);

  state_t      state_reg, state_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic [7:0]  tx_buf_reg, tx_buf_next;
  logic [7:0]  rx_buf_reg, rx_buf_next;
  logic        rx_valid_reg, rx_valid_next;
  logic        ack_reg, ack_next;
  logic [31:0] rdata_reg, rdata_next;
  logic        bus_req_reg, bus_req_next;
  logic        bus_oe_reg, bus_oe_next;
  logic        rdn_reg, rdn_next;
  logic        wrn_reg, wrn_next;
  logic [2:0]  sync1_reg, sync2_reg;

  logic dataready_s, tbre_s, tsre_s;
  logic cpu_req, data_wr, rx_want, rx_last, tx_busy, tx_ready;

  assign dataready_s = sync2_reg[0];
  assign tbre_s      = sync2_reg[1];
  assign tsre_s      = sync2_reg[2];

  // A request is ignored in the ack cycle so a CPU holding req one edge late is not served twice.
  assign cpu_req  = req && !ack_reg;
  assign data_wr  = cpu_req && we && !addr;
  assign rx_want  = dataready_s && !rx_valid_reg;
  assign rx_last  = (state_reg == RX_LOW) && (cnt_reg == RD_LAST);
  assign tx_busy  = state_reg inside {TX_REQ, TX_SETUP, TX_LOW, TX_HOLD, TX_TBRE, TX_TSRE};
  assign tx_ready = !tx_busy && tsre_s;

  always_ff @(posedge clk_50M or negedge reset_n) begin
    if (!reset_n) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= {uart_tsre, uart_tbre, uart_dataready};
      sync2_reg <= sync1_reg;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    tx_buf_next   = tx_buf_reg;
    rx_buf_next   = rx_buf_reg;
    rx_valid_next = rx_valid_reg;
    ack_next      = 1'b0;
    rdata_next    = rdata_reg;
    case (state_reg)
      IDLE: begin
        if (rx_want) begin
          state_next = RX_REQ;
        end else if (data_wr) begin
          state_next  = TX_REQ;
          tx_buf_next = wdata;
          ack_next    = 1'b1;
          rdata_next  = '0;
        end
      end
      RX_REQ: if (bus_gnt) begin state_next = RX_LOW; cnt_next = '0; end
      RX_LOW: begin
        if (cnt_reg == RD_LAST) begin
          rx_buf_next   = bus_din;
          rx_valid_next = 1'b1;
          state_next    = RX_DONE;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      RX_DONE:  state_next = IDLE;
      TX_REQ:   if (bus_gnt) state_next = TX_SETUP;
      TX_SETUP: begin state_next = TX_LOW; cnt_next = '0; end
      TX_LOW: begin
        if (cnt_reg == WR_LAST) state_next = TX_HOLD;
        else cnt_next = cnt_reg + 8'd1;
      end
      TX_HOLD:  state_next = TX_TBRE;
      TX_TBRE:  if (tbre_s) state_next = TX_TSRE;
      TX_TSRE:  if (tsre_s) state_next = IDLE;
      default:  state_next = IDLE;
    endcase

    // Register accesses other than data writes; a data read colliding with the
    // RX capture edge waits one cycle so it returns the fresh byte.
    if (cpu_req && !(we && !addr)) begin
      if (addr) begin
        ack_next   = 1'b1;
        rdata_next = we ? 32'd0 : {30'd0, rx_valid_reg, tx_ready};
      end else if (!rx_last) begin
        ack_next      = 1'b1;
        rdata_next    = rx_valid_reg ? {24'd0, rx_buf_reg} : 32'd0;
        rx_valid_next = 1'b0;
      end
    end
  end

  // Strobes are registered from the next state so the CPLD never sees decode glitches.
  always_comb begin
    bus_req_next = 1'b0;
    bus_oe_next  = 1'b0;
    rdn_next     = 1'b1;
    wrn_next     = 1'b1;
    case (state_next)
      RX_REQ, TX_REQ:    bus_req_next = 1'b1;
      RX_LOW:            begin bus_req_next = 1'b1; rdn_next = 1'b0; end
      TX_SETUP, TX_HOLD: begin bus_req_next = 1'b1; bus_oe_next = 1'b1; end
      TX_LOW:            begin bus_req_next = 1'b1; bus_oe_next = 1'b1; wrn_next = 1'b0; end
      default:           bus_req_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk_50M or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      tx_buf_reg   <= '0;
      rx_buf_reg   <= '0;
      rx_valid_reg <= 1'b0;
      ack_reg      <= 1'b0;
      rdata_reg    <= '0;
      bus_req_reg  <= 1'b0;
      bus_oe_reg   <= 1'b0;
      rdn_reg      <= 1'b1;
      wrn_reg      <= 1'b1;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      tx_buf_reg   <= tx_buf_next;
      rx_buf_reg   <= rx_buf_next;
      rx_valid_reg <= rx_valid_next;
      ack_reg      <= ack_next;
      rdata_reg    <= rdata_next;
      bus_req_reg  <= bus_req_next;
      bus_oe_reg   <= bus_oe_next;
      rdn_reg      <= rdn_next;
      wrn_reg      <= wrn_next;
    end
  end

  assign rdata    = rdata_reg;
  assign ack      = ack_reg;
  assign bus_req  = bus_req_reg;
  assign bus_oe   = bus_oe_reg;
  assign bus_dout = tx_buf_reg;
  assign uart_rdn = rdn_reg;
  assign uart_wrn = wrn_reg;

endmodule

// File: tb/tb_cpld_uart_ctrl.sv
// Directed bench for cpld_uart_ctrl with a small CPLD/arbiter model.
module tb_cpld_uart_ctrl;

  logic        clk_50M = 1'b0;
  logic        reset_n = 1'b0;
  logic        req = 1'b0, we = 1'b0, addr = 1'b0;
  logic [7:0]  wdata = 8'h00;
  logic [31:0] rdata;
  logic        ack, bus_req, bus_gnt, bus_oe, uart_rdn, uart_wrn;
  logic [7:0]  bus_dout, bus_din;
  logic        uart_dataready = 1'b0, uart_tbre = 1'b1, uart_tsre = 1'b1;
  logic        gnt_en = 1'b1;
  logic [7:0]  cpld_byte = 8'h00;
  logic [7:0]  tx_expect = 8'h00;

  int pass_cnt = 0, total_cnt = 0;
  int cyc = 0;
  int rdn_low_tot = 0, wrn_low_tot = 0, oe_tot = 0, dout_bad_tot = 0, both_low_tot = 0;
  int rdn_fall_cyc = -1, rdn_last_cyc = -1, wrn_fall_cyc = -1, oe_rise_cyc = -1;
  logic prev_rdn = 1'b1, prev_wrn = 1'b1, prev_oe = 1'b0;
  int wr_cnt = 0;
  logic [7:0] wr_byte = 8'h00;

  always #10 clk_50M = ~clk_50M;

  assign bus_gnt = gnt_en && bus_req;
  assign bus_din = (uart_rdn === 1'b0) ? cpld_byte : 8'h00;

  cpld_uart_ctrl #(.RD_PULSE(4), .WR_PULSE(4)) dut (
    .clk_50M(clk_50M), .reset_n(reset_n), .req(req), .we(we), .addr(addr),
    .wdata(wdata), .rdata(rdata), .ack(ack), .bus_req(bus_req), .bus_gnt(bus_gnt),
    .bus_dout(bus_dout), .bus_oe(bus_oe), .bus_din(bus_din), .uart_rdn(uart_rdn),
    .uart_wrn(uart_wrn), .uart_dataready(uart_dataready), .uart_tbre(uart_tbre),
    .uart_tsre(uart_tsre)
  );

  always @(posedge clk_50M) cyc <= cyc + 1;

  always @(negedge clk_50M) begin
    if (uart_rdn === 1'b0) begin
      rdn_low_tot <= rdn_low_tot + 1;
      rdn_last_cyc <= cyc;
      if (prev_rdn) rdn_fall_cyc <= cyc;
    end
    if (uart_wrn === 1'b0) begin
      wrn_low_tot <= wrn_low_tot + 1;
      if (prev_wrn) wrn_fall_cyc <= cyc;
    end
    if (bus_oe === 1'b1) begin
      oe_tot <= oe_tot + 1;
      if (!prev_oe) oe_rise_cyc <= cyc;
      if (bus_dout !== tx_expect) dout_bad_tot <= dout_bad_tot + 1;
    end
    if (uart_rdn === 1'b0 && uart_wrn === 1'b0) both_low_tot <= both_low_tot + 1;
    prev_rdn <= (uart_rdn !== 1'b0);
    prev_wrn <= (uart_wrn !== 1'b0);
    prev_oe  <= (bus_oe === 1'b1);
  end

  always @(posedge uart_wrn) begin
    wr_byte <= bus_dout;
    wr_cnt  <= wr_cnt + 1;
  end

  // Called at a negedge; returns at the negedge where ack is seen.
  task automatic cpu_access(input logic w, input logic a, input logic [7:0] d,
                            input int max_cyc, output logic [31:0] rd, output int waited);
    req = 1'b1; we = w; addr = a; wdata = d;
    waited = -1; rd = 32'hDEAD_BEEF;
    for (int i = 1; i <= max_cyc; i++) begin
      @(posedge clk_50M); @(negedge clk_50M);
      if (ack === 1'b1) begin waited = i; rd = rdata; break; end
    end
    req = 1'b0;
    $display("xact we=%0d addr=%0d wdata=%02h rdata=%08h waited=%0d", w, a, d, rd, waited);
  endtask

  task automatic pc_send_byte(input logic [7:0] b);
    cpld_byte = b;
    uart_dataready = 1'b1;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          @(negedge clk_50M);
          if (uart_rdn === 1'b0) break;
        end
        uart_dataready = 1'b0;
      end
    join_none
  endtask

  task automatic wait_tx_done(input int target);
    for (int i = 0; i < 60; i++) begin
      if (wr_cnt >= target && bus_oe === 1'b0) break;
      @(negedge clk_50M);
    end
  endtask

  task automatic test_reset;
    logic [31:0] rd; int w;
    repeat (2) @(negedge clk_50M);
    total_cnt++; if (uart_rdn !== 1'b1) $display("FAIL rst_rdn got %b exp 1", uart_rdn); else pass_cnt++;
    total_cnt++; if (uart_wrn !== 1'b1) $display("FAIL rst_wrn got %b exp 1", uart_wrn); else pass_cnt++;
    total_cnt++; if (bus_oe !== 1'b0) $display("FAIL rst_oe got %b exp 0", bus_oe); else pass_cnt++;
    total_cnt++; if (bus_req !== 1'b0) $display("FAIL rst_bus_req got %b exp 0", bus_req); else pass_cnt++;
    total_cnt++; if (ack !== 1'b0) $display("FAIL rst_ack got %b exp 0", ack); else pass_cnt++;
    total_cnt++; if (rdata !== 32'd0) $display("FAIL rst_rdata got %h exp 0", rdata); else pass_cnt++;
    total_cnt++; if (bus_dout !== 8'd0) $display("FAIL rst_dout got %h exp 0", bus_dout); else pass_cnt++;
    reset_n = 1'b1;
    repeat (3) @(negedge clk_50M);
    cpu_access(1'b0, 1'b1, 8'h00, 5, rd, w);
    total_cnt++; if (rd !== 32'h1) $display("FAIL rst_status got %h exp 1", rd); else pass_cnt++;
  endtask

  task automatic test_rx;
    logic [31:0] rd; int w, c0, r0;
    uart_tsre = 1'b0;
    repeat (3) @(negedge clk_50M);
    r0 = rdn_low_tot; c0 = cyc;
    pc_send_byte(8'h32);
    repeat (7) @(negedge clk_50M);
    cpu_access(1'b0, 1'b1, 8'h00, 5, rd, w);
    total_cnt++; if (rd !== 32'h0) $display("FAIL rx_status_early got %h exp 0", rd); else pass_cnt++;
    for (int i = 0; i < 20 && uart_rdn !== 1'b1; i++) @(negedge clk_50M);
    total_cnt++; if (rdn_fall_cyc - c0 !== 4) $display("FAIL rx_rdn_start got %0d exp 4", rdn_fall_cyc - c0); else pass_cnt++;
    total_cnt++; if (rdn_low_tot - r0 !== 4) $display("FAIL rx_rdn_width got %0d exp 4", rdn_low_tot - r0); else pass_cnt++;
    cpu_access(1'b0, 1'b1, 8'h00, 5, rd, w);
    total_cnt++; if (rd !== 32'h2) $display("FAIL rx_status got %h exp 2", rd); else pass_cnt++;
    cpu_access(1'b0, 1'b0, 8'h00, 5, rd, w);
    total_cnt++; if (rd !== 32'h32) $display("FAIL rx_data got %h exp 32", rd); else pass_cnt++;
    cpu_access(1'b0, 1'b1, 8'h00, 5, rd, w);
    total_cnt++; if (rd !== 32'h0) $display("FAIL rx_status_clr got %h exp 0", rd); else pass_cnt++;
    uart_tsre = 1'b1;
    repeat (3) @(negedge clk_50M);
    cpu_access(1'b0, 1'b1, 8'h00, 5, rd, w);
    total_cnt++; if (rd !== 32'h1) $display("FAIL rx_status_tsre got %h exp 1", rd); else pass_cnt++;
  endtask

  task automatic test_tx;
    logic [31:0] rd; int w, o0, wl0, b0, wc0;
    repeat (3) @(negedge clk_50M);
    o0 = oe_tot; wl0 = wrn_low_tot; b0 = dout_bad_tot; wc0 = wr_cnt;
    tx_expect = 8'h41;
    cpu_access(1'b1, 1'b0, 8'h41, 5, rd, w);
    total_cnt++; if (w !== 1) $display("FAIL tx_ack got %0d exp 1", w); else pass_cnt++;
    uart_tbre = 1'b0;
    cpu_access(1'b0, 1'b1, 8'h00, 5, rd, w);
    total_cnt++; if (rd !== 32'h0) $display("FAIL tx_status_busy got %h exp 0", rd); else pass_cnt++;
    uart_tsre = 1'b0;
    wait_tx_done(wc0 + 1);
    total_cnt++; if (oe_tot - o0 !== 6) $display("FAIL tx_oe_width got %0d exp 6", oe_tot - o0); else pass_cnt++;
    total_cnt++; if (dout_bad_tot - b0 !== 0) $display("FAIL tx_dout got %0d bad cycles exp 0", dout_bad_tot - b0); else pass_cnt++;
    total_cnt++; if (wrn_low_tot - wl0 !== 4) $display("FAIL tx_wrn_width got %0d exp 4", wrn_low_tot - wl0); else pass_cnt++;
    total_cnt++; if (wrn_fall_cyc - oe_rise_cyc !== 1) $display("FAIL tx_wrn_offset got %0d exp 1", wrn_fall_cyc - oe_rise_cyc); else pass_cnt++;
    total_cnt++; if (wr_byte !== 8'h41) $display("FAIL tx_byte got %h exp 41", wr_byte); else pass_cnt++;
    cpu_access(1'b0, 1'b1, 8'h00, 5, rd, w);
    total_cnt++; if (rd !== 32'h0) $display("FAIL tx_status_tbre got %h exp 0", rd); else pass_cnt++;
    uart_tbre = 1'b1;
    repeat (4) @(negedge clk_50M);
    cpu_access(1'b0, 1'b1, 8'h00, 5, rd, w);
    total_cnt++; if (rd !== 32'h0) $display("FAIL tx_status_tsre got %h exp 0", rd); else pass_cnt++;
    uart_tsre = 1'b1;
    repeat (4) @(negedge clk_50M);
    cpu_access(1'b0, 1'b1, 8'h00, 5, rd, w);
    total_cnt++; if (rd !== 32'h1) $display("FAIL tx_status_done got %h exp 1", rd); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    logic [31:0] rd; int w, w2, wc0, b0;
    repeat (3) @(negedge clk_50M);
    wc0 = wr_cnt; b0 = dout_bad_tot;
    tx_expect = 8'h55;
    cpu_access(1'b1, 1'b0, 8'h55, 5, rd, w);
    uart_tbre = 1'b0; uart_tsre = 1'b0;
    wait_tx_done(wc0 + 1);
    tx_expect = 8'hA6;
    fork
      cpu_access(1'b1, 1'b0, 8'hA6, 30, rd, w2);
      begin
        repeat (5) @(negedge clk_50M); uart_tbre = 1'b1;
        repeat (3) @(negedge clk_50M); uart_tsre = 1'b1;
      end
    join
    total_cnt++; if (w2 !== 12) $display("FAIL b2b_stall got %0d exp 12", w2); else pass_cnt++;
    wait_tx_done(wc0 + 2);
    total_cnt++; if (wr_cnt - wc0 !== 2) $display("FAIL b2b_pulses got %0d exp 2", wr_cnt - wc0); else pass_cnt++;
    total_cnt++; if (wr_byte !== 8'hA6) $display("FAIL b2b_byte got %h exp a6", wr_byte); else pass_cnt++;
    total_cnt++; if (dout_bad_tot - b0 !== 0) $display("FAIL b2b_dout got %0d bad cycles exp 0", dout_bad_tot - b0); else pass_cnt++;
  endtask

  task automatic test_rx_priority;
    logic [31:0] rd; int w, wc0;
    repeat (3) @(negedge clk_50M);
    wc0 = wr_cnt;
    pc_send_byte(8'h7E);
    fork
      begin
        repeat (2) @(negedge clk_50M);
        tx_expect = 8'h99;
        cpu_access(1'b1, 1'b0, 8'h99, 30, rd, w);
      end
    join
    total_cnt++; if (w !== 8) $display("FAIL prio_write_stall got %0d exp 8", w); else pass_cnt++;
    wait_tx_done(wc0 + 1);
    total_cnt++; if (!(wrn_fall_cyc > rdn_last_cyc)) $display("FAIL prio_order got wrn_start=%0d rdn_last=%0d exp wrn after rdn", wrn_fall_cyc, rdn_last_cyc); else pass_cnt++;
    total_cnt++; if (wr_byte !== 8'h99) $display("FAIL prio_tx_byte got %h exp 99", wr_byte); else pass_cnt++;
    total_cnt++; if (both_low_tot !== 0) $display("FAIL prio_both_low got %0d exp 0", both_low_tot); else pass_cnt++;
    cpu_access(1'b0, 1'b0, 8'h00, 5, rd, w);
    total_cnt++; if (rd !== 32'h7E) $display("FAIL prio_rx_data got %h exp 7e", rd); else pass_cnt++;
  endtask

  task automatic test_gnt_wait;
    logic [31:0] rd; int w, o0, wl0, r0, drops, wc0;
    repeat (3) @(negedge clk_50M);
    gnt_en = 1'b0; drops = 0;
    o0 = oe_tot; wl0 = wrn_low_tot; r0 = rdn_low_tot; wc0 = wr_cnt;
    tx_expect = 8'h3C;
    cpu_access(1'b1, 1'b0, 8'h3C, 5, rd, w);
    total_cnt++; if (w !== 1) $display("FAIL gnt_ack got %0d exp 1", w); else pass_cnt++;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_50M);
      if (bus_req !== 1'b1) drops++;
    end
    total_cnt++; if (drops !== 0) $display("FAIL gnt_req_hold got %0d low cycles exp 0", drops); else pass_cnt++;
    total_cnt++; if (oe_tot - o0 !== 0) $display("FAIL gnt_oe_idle got %0d exp 0", oe_tot - o0); else pass_cnt++;
    total_cnt++; if ((wrn_low_tot - wl0) + (rdn_low_tot - r0) !== 0) $display("FAIL gnt_strobe_idle got %0d exp 0", (wrn_low_tot - wl0) + (rdn_low_tot - r0)); else pass_cnt++;
    gnt_en = 1'b1;
    wait_tx_done(wc0 + 1);
    total_cnt++; if (wr_byte !== 8'h3C) $display("FAIL gnt_byte got %h exp 3c", wr_byte); else pass_cnt++;
    total_cnt++; if (oe_tot - o0 !== 6) $display("FAIL gnt_oe_width got %0d exp 6", oe_tot - o0); else pass_cnt++;
  endtask

  task automatic test_reset_mid_tx;
    logic [31:0] rd; int w;
    uart_tbre = 1'b0; uart_tsre = 1'b0;
    repeat (3) @(negedge clk_50M);
    tx_expect = 8'h5A;
    cpu_access(1'b1, 1'b0, 8'h5A, 5, rd, w);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_50M);
      if (uart_wrn === 1'b0) break;
    end
    total_cnt++; if (uart_wrn !== 1'b0) $display("FAIL rmid_in_tx_low got wrn=%b exp 0", uart_wrn); else pass_cnt++;
    #2 reset_n = 1'b0;
    #1;
    total_cnt++; if (uart_wrn !== 1'b1) $display("FAIL rmid_wrn got %b exp 1", uart_wrn); else pass_cnt++;
    total_cnt++; if (uart_rdn !== 1'b1) $display("FAIL rmid_rdn got %b exp 1", uart_rdn); else pass_cnt++;
    total_cnt++; if (bus_oe !== 1'b0) $display("FAIL rmid_oe got %b exp 0", bus_oe); else pass_cnt++;
    total_cnt++; if (bus_req !== 1'b0) $display("FAIL rmid_bus_req got %b exp 0", bus_req); else pass_cnt++;
    @(negedge clk_50M);
    reset_n = 1'b1;
    @(negedge clk_50M);
    cpu_access(1'b0, 1'b1, 8'h00, 5, rd, w);
    total_cnt++; if (rd !== 32'h0) $display("FAIL rmid_status got %h exp 0", rd); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_rx();
    test_tx();
    test_back_to_back();
    test_rx_priority();
    test_gnt_wait();
    test_reset_mid_tx();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
